// File: rtl/methane_board_top.sv
// -----------------------------------------------------------------------------
// methane_board_top
// Board-level top for the methane build. Conditions the active-low K2 push
// button (2-flop synchroniser + counter debounce), turns each debounced press
// into a one-cycle event that toggles run/pause and counts presses, and shows
// {press count, run-gated tick count} on the 16-bit LED bus.
//
// Ports:
//   clk_in_50M  in   1   50 MHz board clock, only clock domain
//   rst         in   1   asynchronous reset, active low
//   btn_k2      in   1   raw push button, active low, asynchronous, bouncy
//   out         out  16  LED bus: [15:8] press count, [7:0] tick count
//
// Run/pause state machine:
//   state | meaning
//   PAUSE | run=0, tick divider and tick count hold (reset state)
//   RUN   | run=1, tick divider advances, tick count bumps on divider wrap
// -----------------------------------------------------------------------------
module methane_board_top #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 25000000
) (
    input  logic        clk_in_50M,
    input  logic        rst,
    input  logic        btn_k2,
    output logic [15:0] out
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    logic             r_sync_ff1;
    logic             r_sync_ff2;
    logic             r_btn_db;
    logic             r_btn_db_prev;
    logic [DB_W-1:0]  r_db_cnt;
    logic [7:0]       r_press_cnt;
    logic [7:0]       r_tick_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [15:0]      r_out;
    state_t           r_state;

    state_t           w_state_nxt;
    logic             w_run;
    logic             w_press;

    // Synchroniser and debounce. Both flops and the debounced level reset to
    // the released level so a button held through reset must debounce low
    // before it can count as a press.
    always_ff @(posedge clk_in_50M or negedge rst) begin
        if (!rst) begin
            r_sync_ff1    <= 1'b1;
            r_sync_ff2    <= 1'b1;
            r_btn_db      <= 1'b1;
            r_btn_db_prev <= 1'b1;
            r_db_cnt      <= '0;
        end else begin
            r_sync_ff1    <= btn_k2;
            r_sync_ff2    <= r_sync_ff1;
            r_btn_db_prev <= r_btn_db;
            if (r_sync_ff2 == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_db <= r_sync_ff2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_ONE;
            end
        end
    end

    // Debounced falling edge only; release produces no event.
    assign w_press = r_btn_db_prev & ~r_btn_db;

    always_ff @(posedge clk_in_50M or negedge rst) begin
        if (!rst) begin
            r_state <= PAUSE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            PAUSE: begin
                w_run = 1'b0;
                if (w_press) w_state_nxt = RUN;
            end
            RUN: begin
                w_run = 1'b1;
                if (w_press) w_state_nxt = PAUSE;
            end
            default: w_state_nxt = PAUSE;
        endcase
    end

    always_ff @(posedge clk_in_50M or negedge rst) begin
        if (!rst) begin
            r_press_cnt <= '0;
        end else if (w_press) begin
            r_press_cnt <= r_press_cnt + 8'd1;
        end
    end

    // The divider decision uses the pre-toggle run value, so a press landing
    // on a divider wrap still lets that tick through. Pause holds, not clears.
    always_ff @(posedge clk_in_50M or negedge rst) begin
        if (!rst) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
        end else if (w_run) begin
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= r_tick_cnt + 8'd1;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_ONE;
            end
        end
    end

    always_ff @(posedge clk_in_50M or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
        end else begin
            r_out <= {r_press_cnt, r_tick_cnt};
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_methane_board_top.sv
// -----------------------------------------------------------------------------
// tb_methane_board_top
// Bench for methane_board_top with short debounce/tick parameters. A
// behavioural model (sample history window, integer press/tick totals) predicts
// the LED bus every cycle; a few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_methane_board_top;

    localparam int DEB  = 8;
    localparam int TICK = 4;

    logic        clk;
    logic        rst;
    logic        btn;
    logic [15:0] out;

    int n_cmp = 0;
    int n_err = 0;
    int n_model_fail_prints = 0;

    methane_board_top #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES    (TICK)
    ) dut (
        .clk_in_50M(clk),
        .rst       (rst),
        .btn_k2    (btn),
        .out       (out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_q holds the last DEB+2 raw button samples taken at rising edges; the
    // synchronised level seen at an edge is the sample from two edges before.
    int          m_q[$];
    bit          m_db;
    bit          m_db_prev;
    int          m_presses;
    int          m_ticks;
    int          m_div;
    logic [15:0] m_out;
    bit          m_valid = 1'b0;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < DEB + 2; i++) m_q.push_back(1);
        m_db      = 1'b1;
        m_db_prev = 1'b1;
        m_presses = 0;
        m_ticks   = 0;
        m_div     = 0;
        m_out     = 16'h0000;
        m_valid   = 1'b1;
    endtask

    task automatic model_step();
        bit all_diff;
        bit press;
        bit running;
        m_q.push_back(int'(btn));
        void'(m_q.pop_front());
        all_diff = 1'b1;
        for (int i = 0; i < DEB; i++)
            if (m_q[i] == int'(m_db)) all_diff = 1'b0;
        press   = m_db_prev && !m_db;
        running = (m_presses % 2) == 1;
        m_out   = {8'(m_presses % 256), 8'(m_ticks % 256)};
        if (running) begin
            m_div = m_div + 1;
            if (m_div == TICK) begin
                m_div   = 0;
                m_ticks = m_ticks + 1;
            end
        end
        if (press) m_presses = m_presses + 1;
        m_db_prev = m_db;
        if (all_diff) m_db = ~m_db;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else if (m_valid) model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                n_cmp++;
                if (out !== m_out) begin
                    n_err++;
                    if (n_model_fail_prints < 20) begin
                        n_model_fail_prints++;
                        $display("FAIL model_cmp t=%0t out=%h expected=%h", $time, out, m_out);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        btn = v;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int   found;
        int   changes;
        logic [7:0] t0;
        logic [7:0] prev;

        rst = 1'b1;
        btn = 1'b1;

        // Reset behaviour
        #500 rst = 1'b0;
        #50 check("out_in_reset", int'(out), 0);
        #50 rst = 1'b1;
        cyc(20);
        check("out_after_reset", int'(out), 0);
        cyc(20);
        check("tick_paused_after_reset", int'(out[7:0]), 0);

        // Single press: visible within 2+8+2 cycles
        drive(1'b0);
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out[15:8] == 8'h01) begin
                found = 1;
                break;
            end
        end
        check("press_latency", found, 1);
        cyc(40);
        check("held_press_count_tick", int'(out), 16'h010A);

        // Bounce: toggle every 3 cycles for 60 cycles, then random short glitches
        for (int i = 0; i < 20; i++) begin
            btn = ~btn;
            cyc(3);
        end
        btn = 1'b1;
        cyc(20);
        for (int i = 0; i < 10; i++) begin
            btn = 1'b0;
            cyc($urandom_range(1, 6));
            btn = 1'b1;
            cyc($urandom_range(1, 6));
        end
        cyc(20);
        check("bounce_press_cnt", int'(out[15:8]), 1);
        t0 = out[7:0];
        cyc(8);
        check("bounce_run_kept", int'(out[7:0] != t0), 1);

        // Pause: second clean press
        drive(1'b0);
        cyc(16);
        check("pause_press_cnt", int'(out[15:8]), 2);
        t0 = out[7:0];
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out[7:0] != t0) changes++;
        end
        check("pause_tick_frozen", changes, 0);
        drive(1'b1);
        cyc(14);

        // Press count wrap: total of 256 presses
        for (int i = 0; i < 254; i++) begin
            drive(1'b0);
            cyc($urandom_range(11, 14));
            drive(1'b1);
            cyc($urandom_range(11, 14));
        end
        cyc(4);
        check("press_wrap", int'(out[15:8]), 0);
        t0 = out[7:0];
        cyc(12);
        check("even_presses_paused", int'(out[7:0]), int'(t0));

        // Tick wrap while running
        drive(1'b0);
        found = 0;
        prev  = out[7:0];
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (prev == 8'hFF && out[7:0] == 8'h00) found = 1;
            prev = out[7:0];
        end
        check("tick_wrap", found, 1);
        check("press_after_wrap", int'(out[15:8]), 1);

        // Asynchronous reset mid-cycle with the button held
        @(posedge clk);
        #5 rst = 1'b0;
        #1 check("async_reset_out", int'(out), 0);
        cyc(3);
        @(negedge clk);
        #4 rst = 1'b1;
        found = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (out[15:8] == 8'h01) begin
                found = 1;
                break;
            end
        end
        check("held_through_reset_press", found, 1);
        cyc(10);
        check("held_through_reset_count", int'(out[15:8]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/methane_board_top.md
Name: methane_board_top

Overview:
- Board-level top for the methane FPGA build, driven by the 50 MHz board oscillator.
- Conditions the active-low push button K2: 2-flop synchroniser plus counter-based debounce.
- Turns each debounced press into a one-cycle event that toggles a run/pause state and counts presses.
- Drives a 16-bit LED bus: press count in the upper byte, a run-gated tick counter in the lower byte.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised samples required before the debounced level changes (20 ms at 50 MHz).
- TICK_CYCLES, 25000000: clock cycles per tick-counter increment while running (0.5 s at 50 MHz).

Ports:
- clk_in_50M  input  1  50 MHz board clock; the only clock domain.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_k2  input  1  raw push button, active-low (0 = pressed), asynchronous to the clock, may bounce.
- out  output  16  LED bus; out[15:8] = press_cnt, out[7:0] = tick_cnt.

Behaviour:
- Reset: all flops clear asynchronously on rst=0, with these values:
  - sync_ff1, sync_ff2, btn_db = 1
  - db_cnt = 0
  - run = 0
  - press_cnt = 0, tick_cnt = 0, div_cnt = 0
  - out = 16'h0000
- Leaving reset: synchronous to the next clk_in_50M rising edge after rst returns to 1.
- Synchroniser: btn_k2 -> sync_ff1 -> sync_ff2, two flops; only sync_ff2 is used downstream.
- Debounce, when sync_ff2 == btn_db:
  - db_cnt = 0.
- Debounce, when sync_ff2 != btn_db:
  - db_cnt increments each cycle.
  - When db_cnt reaches DEBOUNCE_CYCLES-1 while still differing, btn_db <= sync_ff2 and db_cnt <= 0.
  - Any return to equality before that clears db_cnt (glitch rejected).
- Latency from a clean btn_k2 edge to a btn_db change: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles.
- Press event: press = btn_db_prev & ~btn_db (debounced 1->0 transition).
  - Exactly one cycle wide.
  - Release (0->1) produces no event.
- Run/pause state machine, states PAUSE (run=0, reset state) and RUN (run=1):
  - Each press event toggles the state.
  - Holding the button produces only one event.
- press_cnt: 8-bit counter; increments on every press event; wraps 255 -> 0.
- Tick divider:
  - In RUN, div_cnt counts 0..TICK_CYCLES-1.
  - On reaching TICK_CYCLES-1, div_cnt <= 0 and tick_cnt increments (8-bit, wraps 255 -> 0).
  - In PAUSE, div_cnt and tick_cnt hold their values; they are not cleared.
  - RUN after PAUSE resumes from the held div_cnt.
- Same-cycle press and divider wrap: tick_cnt increments in that cycle (decision uses the pre-toggle run value); run toggles.
- out: registered, equal to {press_cnt, tick_cnt}, updated one cycle after the counters change.
- Reset mid-operation: asynchronous return to the reset values regardless of button level.
  - A button held through reset release produces no press event, because btn_db starts at 1 and must first debounce low.
  - That held press then counts as one press after DEBOUNCE_CYCLES.
- No combinational path from btn_k2 to out.

Test Plan (all scenarios with DEBOUNCE_CYCLES=8, TICK_CYCLES=4, 20 ns clock):
- Reset behaviour:
  - Stimulus: rst=1 for 500 ns, rst=0 for 100 ns, rst=1, btn_k2=1 throughout.
  - Required: out=16'h0000 during and after reset; tick_cnt stays 0 (PAUSE).
- Single press:
  - Stimulus: btn_k2 driven 0 and held.
  - Required: out[15:8] becomes 8'h01 within 2+8+2 cycles; afterwards out[7:0] increments every 4 cycles (0x01, 0x02, ...).
  - Required: no further press_cnt change while the button is held.
- Bounce rejection:
  - Stimulus: btn_k2 toggles every 3 cycles for 60 cycles, then settles at 1.
  - Required: press_cnt unchanged; run unchanged.
- Pause:
  - Stimulus: release, then a second clean press held more than 10 cycles.
  - Required: press_cnt=2; tick_cnt freezes at its current value and stays constant for 40 cycles.
- Wrap-around:
  - Stimulus: 256 clean presses.
  - Required: press_cnt wraps to 8'h00; run equals 0 (even count).
  - Stimulus: RUN for 1024 cycles.
  - Required: tick_cnt wraps 0xFF -> 0x00.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously mid-cycle while in RUN with the button held.
  - Required: out=0 immediately.
  - Stimulus: release rst with the button still held.
  - Required: press_cnt becomes 1 after debounce.
